// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass, optional zero register
// and a one-entry-per-cycle clear sweep after reset.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         RegWrite,
  input  logic [ADDR_W-1:0]            Write_register,
  input  logic [DATA_W-1:0]            Write_data,
  input  logic [NUM_READ*ADDR_W-1:0]   Read_register,
  output logic [NUM_READ*DATA_W-1:0]   Read_data,
  output logic                         Init_busy,
  output logic                         Write_dropped
);

  localparam int N = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(N - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W:0]   ptr_q;
  logic [ADDR_W:0]   ptr_d;
  logic              drop_q;
  logic              drop_d;

  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              zero_hit;
  logic              wr_live;

  logic [DATA_W-1:0] mem [N];
  logic [DATA_W-1:0] rd [NUM_READ];

  assign zero_hit = (ZERO_REG != 0) && (Write_register == '0);
  assign wr_live  = (state_q == READY) && RegWrite && !zero_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    drop_d  = drop_q;
    we      = 1'b0;
    wa      = Write_register;
    wd      = Write_data;
    unique case (state_q)
      CLEAR: begin
        we    = 1'b1;
        wa    = ptr_q[ADDR_W-1:0];
        wd    = '0;
        ptr_d = ptr_q + 1'b1;
        if (RegWrite) drop_d = 1'b1;
        if (ptr_q == LAST) state_d = READY;
      end
      READY: begin
        we = wr_live;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Single write port, no reset on the array so it can map to RAM
  always_ff @(posedge clk) begin
    if (!reset && we) begin
      mem[wa] <= wd;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = Read_register[p*ADDR_W +: ADDR_W];

    always_comb begin
      if (state_q != READY) begin
        rd[p] = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd[p] = '0;
      end else if ((BYPASS != 0) && wr_live
                   && (Write_register == ra)) begin
        rd[p] = Write_data;
      end else begin
        rd[p] = mem[ra];
      end
    end
  end

  always_comb begin
    Read_data = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      Read_data[p*DATA_W +: DATA_W] = rd[p];
    end
  end

  assign Init_busy     = (state_q == CLEAR);
  assign Write_dropped = drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus random traffic
// checked against an array model of the register file.
module tb_regfile_mp;

  logic         clk = 1'b0;
  logic         reset;
  logic         reg_write;
  logic [4:0]   wr_reg;
  logic [31:0]  wr_data;
  logic [19:0]  rd_reg;
  logic [127:0] rd_data;
  logic         busy;
  logic         dropped;
  logic [63:0]  rd_data_nb;
  logic         busy_nb;
  logic         dropped_nb;

  int n_tests = 0;
  int n_fail = 0;

  logic [31:0] m [32];
  int          left = 32;
  bit          mdrop = 1'b0;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_READ(4),
    .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .RegWrite(reg_write),
    .Write_register(wr_reg),
    .Write_data(wr_data),
    .Read_register(rd_reg),
    .Read_data(rd_data),
    .Init_busy(busy),
    .Write_dropped(dropped)
  );

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_READ(2),
    .ZERO_REG(1), .BYPASS(0)
  ) dut_nb (
    .clk(clk),
    .reset(reset),
    .RegWrite(reg_write),
    .Write_register(wr_reg),
    .Write_data(wr_data),
    .Read_register(rd_reg[9:0]),
    .Read_data(rd_data_nb),
    .Init_busy(busy_nb),
    .Write_dropped(dropped_nb)
  );

  function automatic logic [31:0] port(int p);
    return rd_data[p*32 +: 32];
  endfunction

  function automatic logic [31:0] nbport(int p);
    return rd_data_nb[p*32 +: 32];
  endfunction

  function automatic logic [4:0] raddr(int p);
    return rd_reg[p*5 +: 5];
  endfunction

  // Expected read value from the model's view of the register file
  function automatic logic [31:0] exp_rd(logic [4:0] a, bit byp);
    if (left != 0) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (byp && reg_write && wr_reg == a) return wr_data;
    return m[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      left  = 32;
      mdrop = 1'b0;
    end else if (left != 0) begin
      m[32-left] = 32'h0;
      left--;
      if (reg_write) mdrop = 1'b1;
    end else if (reg_write && wr_reg != 5'd0) begin
      m[wr_reg] = wr_data;
    end
    @(negedge clk);
  endtask

  task automatic write(logic [4:0] a, logic [31:0] d);
    reg_write = 1'b1;
    wr_reg    = a;
    wr_data   = d;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic all_ports(logic [4:0] a);
    rd_reg = {a, a, a, a};
  endtask

  task automatic run_sweep(output int cnt, output int bad);
    cnt = 0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      rd_reg = 20'($urandom);
      #1;
      if (!busy) break;
      cnt++;
      if (rd_data !== '0 || rd_data_nb !== '0) bad++;
      tick();
    end
  endtask

  task automatic check_all_zero(string name);
    for (int a = 0; a < 32; a++) begin
      all_ports(5'(a));
      #1;
      n_tests++;
      if (rd_data !== '0 || rd_data_nb !== '0) begin
        n_fail++;
        $display("FAIL %s reg %0d got %h/%h exp 0",
                 name, a, rd_data, rd_data_nb);
      end
    end
  endtask

  task automatic test_reset();
    int cnt;
    int bad;
    reset = 1'b1;
    repeat (3) tick();
    #1;
    n_tests++;
    if (busy !== 1'b1 || dropped !== 1'b0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state busy=%b drop=%b rd=%h exp 1/0/0",
               busy, dropped, rd_data);
    end
    reset = 1'b0;
    run_sweep(cnt, bad);
    n_tests++;
    if (cnt !== 32) begin
      n_fail++;
      $display("FAIL sweep_len got %0d exp 32", cnt);
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL sweep_reads nonzero=%0d exp 0", bad);
    end
    check_all_zero("post_sweep");
  endtask

  task automatic test_write_read();
    write(5'd25, 32'd15);
    write(5'd3, 32'd3);
    rd_reg = {10'd0, 5'd3, 5'd25};
    #1;
    n_tests++;
    if (port(0) !== 32'd15 || port(1) !== 32'd3) begin
      n_fail++;
      $display("FAIL rd_25_3 got %h/%h exp 0000000f/00000003",
               port(0), port(1));
    end
    n_tests++;
    if (nbport(0) !== 32'd15 || nbport(1) !== 32'd3) begin
      n_fail++;
      $display("FAIL rd_25_3_nb got %h/%h exp 0000000f/00000003",
               nbport(0), nbport(1));
    end
    reg_write = 1'b1;
    wr_reg    = 5'd0;
    wr_data   = 32'hDEAD_BEEF;
    all_ports(5'd0);
    #1;
    n_tests++;
    if (port(0) !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_bypass got %h exp 0", port(0));
    end
    tick();
    reg_write = 1'b0;
    #1;
    n_tests++;
    if (rd_data !== '0 || rd_data_nb !== '0 || dropped !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_reg rd=%h drop=%b exp 0/0", rd_data, dropped);
    end
  endtask

  task automatic test_bypass();
    reg_write = 1'b1;
    wr_reg    = 5'd7;
    wr_data   = 32'h1234;
    rd_reg    = {15'd0, 5'd7};
    #1;
    n_tests++;
    if (port(0) !== 32'h1234) begin
      n_fail++;
      $display("FAIL bypass_same got %h exp 00001234", port(0));
    end
    n_tests++;
    if (nbport(0) !== 32'h0) begin
      n_fail++;
      $display("FAIL nobypass_same got %h exp 0", nbport(0));
    end
    tick();
    reg_write = 1'b0;
    #1;
    n_tests++;
    if (nbport(0) !== 32'h1234 || port(0) !== 32'h1234) begin
      n_fail++;
      $display("FAIL bypass_next got %h/%h exp 00001234",
               port(0), nbport(0));
    end
  endtask

  task automatic test_drop_in_sweep();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 32; k++) begin
      reg_write = (k == 10);
      wr_reg    = 5'd4;
      wr_data   = 32'h55;
      #1;
      if (k == 10 || k == 11) begin
        n_tests++;
        if (dropped !== (k == 11)) begin
          n_fail++;
          $display("FAIL drop_edge k=%0d got %b exp %b",
                   k, dropped, k == 11);
        end
      end
      tick();
    end
    reg_write = 1'b0;
    all_ports(5'd4);
    #1;
    n_tests++;
    if (busy !== 1'b0 || port(0) !== 32'h0 || dropped !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_after busy=%b r4=%h drop=%b exp 0/0/1",
               busy, port(0), dropped);
    end
    write(5'd5, 32'h7);
    #1;
    n_tests++;
    if (dropped !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_sticky got %b exp 1", dropped);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    int bad;
    for (int a = 0; a < 32; a++) write(5'(a), 32'(a + 100));
    for (int a = 0; a < 32; a++) begin
      all_ports(5'(a));
      #1;
      n_tests++;
      if (port(3) !== ((a == 0) ? 32'h0 : 32'(a + 100))) begin
        n_fail++;
        $display("FAIL fill reg %0d got %h", a, port(3));
      end
    end
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    n_tests++;
    if (dropped !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_clear got %b exp 0", dropped);
    end
    repeat (12) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    run_sweep(cnt, bad);
    n_tests++;
    if (cnt !== 32 || bad !== 0) begin
      n_fail++;
      $display("FAIL resweep len=%0d bad=%0d exp 32/0", cnt, bad);
    end
    check_all_zero("resweep");
  endtask

  task automatic test_four_ports();
    write(5'd9, 32'h99);
    all_ports(5'd9);
    #1;
    for (int p = 0; p < 4; p++) begin
      n_tests++;
      if (port(p) !== 32'h99) begin
        n_fail++;
        $display("FAIL same_reg port %0d got %h exp 00000099",
                 p, port(p));
      end
    end
    write(5'd1, 32'h11);
    write(5'd2, 32'h22);
    write(5'd30, 32'h3030);
    write(5'd31, 32'h3131);
    rd_reg = {5'd31, 5'd30, 5'd2, 5'd1};
    #1;
    n_tests++;
    if (rd_data !== {32'h3131, 32'h3030, 32'h22, 32'h11}) begin
      n_fail++;
      $display("FAIL distinct got %h", rd_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      reg_write = $urandom_range(0, 1);
      wr_reg    = ($urandom_range(0, 3) == 0) ?
                  5'($urandom_range(0, 3)) : 5'($urandom);
      wr_data   = $urandom;
      rd_reg    = ($urandom_range(0, 3) == 0) ?
                  {4{wr_reg}} : 20'($urandom);
      #1;
      n_tests++;
      if (busy !== (left != 0) || dropped !== mdrop) begin
        n_fail++;
        $display("FAIL rnd_flags i=%0d busy=%b drop=%b exp %b/%b",
                 i, busy, dropped, left != 0, mdrop);
      end
      for (int p = 0; p < 4; p++) begin
        n_tests++;
        if (port(p) !== exp_rd(raddr(p), 1'b1)) begin
          n_fail++;
          $display("FAIL rnd_rd i=%0d p=%0d got %h exp %h",
                   i, p, port(p), exp_rd(raddr(p), 1'b1));
        end
      end
      for (int p = 0; p < 2; p++) begin
        n_tests++;
        if (nbport(p) !== exp_rd(raddr(p), 1'b0)) begin
          n_fail++;
          $display("FAIL rnd_nb i=%0d p=%0d got %h exp %h",
                   i, p, nbport(p), exp_rd(raddr(p), 1'b0));
        end
      end
      tick();
    end
    reset     = 1'b0;
    reg_write = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    reg_write = 1'b0;
    wr_reg    = '0;
    wr_data   = '0;
    rd_reg    = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_drop_in_sweep();
    test_reset_mid_sweep();
    test_four_ports();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
